// File: rtl/irig_sync_ctrl.sv
// IRIG-B sync supervisor: qualifies the decoder's raw PPS and timestamp,
// runs a SEARCH/ACQUIRE/LOCKED/HOLDOVER lock machine and publishes the
// qualified PPS and time. During dropouts it free-runs for a bounded holdover.
module irig_sync_ctrl #(
    parameter int unsigned CLK_HZ       = 10000000,
    parameter int unsigned PPS_TOL      = 100,
    parameter int unsigned LOCK_COUNT   = 3,
    parameter int unsigned HOLDOVER_MAX = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pps_in,
    input  logic [16:0] ts_sec_day_in,
    input  logic [8:0]  ts_day_in,
    input  logic [6:0]  ts_year_in,
    output logic        pps_out,
    output logic [16:0] sec_day_out,
    output logic [8:0]  day_out,
    output logic [6:0]  year_out,
    output logic        locked,
    output logic        holdover,
    output logic [1:0]  state
);

    localparam int unsigned CW = $clog2(2 * CLK_HZ + 1);
    localparam logic [CW-1:0] CNT_SAT = CW'(2 * CLK_HZ);
    localparam logic [CW-1:0] CNT_NOM = CW'(CLK_HZ - 1);
    localparam logic [CW-1:0] CNT_MIN = CW'(CLK_HZ - 1 - PPS_TOL);
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1 + PPS_TOL);
    localparam logic [CW-1:0] CNT_TMO = CW'(CLK_HZ + PPS_TOL);
    localparam logic [3:0]    LOCK_N  = 4'(LOCK_COUNT);
    localparam logic [7:0]    HOLD_N  = 8'(HOLDOVER_MAX);

    typedef enum logic [1:0] {
        StSearch   = 2'd0,
        StAcquire  = 2'd1,
        StLocked   = 2'd2,
        StHoldover = 2'd3
    } state_e;

    typedef struct packed {
        logic [16:0] sec;
        logic [8:0]  day;
        logic [6:0]  year;
    } ts_t;

    // Advance a timestamp by one second, including day, leap-year and century wrap.
    function automatic ts_t ts_inc(input ts_t t);
        ts_t r;
        r = t;
        if (t.sec == 17'd86399) begin
            r.sec = '0;
            if ((t.day == 9'd366 && t.year[1:0] == 2'd0) ||
                (t.day == 9'd365 && t.year[1:0] != 2'd0)) begin
                r.day  = 9'd1;
                r.year = (t.year == 7'd99) ? 7'd0 : t.year + 7'd1;
            end else begin
                r.day = t.day + 9'd1;
            end
        end else begin
            r.sec = t.sec + 17'd1;
        end
        return r;
    endfunction

    function automatic logic ts_in_range(input ts_t t);
        return (t.sec <= 17'd86399) && (t.day != 9'd0) && (t.day <= 9'd366);
    endfunction

    // {locked, holdover} that go with a given state, so flags change with the state.
    function automatic logic [1:0] st_flags(input state_e s);
        return {s == StLocked, s == StHoldover};
    endfunction

    state_e        state_q;
    logic          pps_q;
    logic [CW-1:0] cnt;
    logic [3:0]    good_cnt;
    logic [7:0]    ho_cnt;
    ts_t           prev_ts;
    ts_t           pub_ts;

    logic ev;
    ts_t  sample;
    logic good;

    assign ev     = pps_in & ~pps_q;
    assign sample = '{sec: ts_sec_day_in, day: ts_day_in, year: ts_year_in};
    assign good   = (cnt >= CNT_MIN) && (cnt <= CNT_MAX) &&
                    ts_in_range(sample) && (sample == ts_inc(prev_ts));

    assign state       = state_q;
    assign sec_day_out = pub_ts.sec;
    assign day_out     = pub_ts.day;
    assign year_out    = pub_ts.year;

    // Lock FSM, interval/holdover counters and registered publish outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StSearch;
            locked   <= 1'b0;
            holdover <= 1'b0;
            pps_out  <= 1'b0;
            pps_q    <= 1'b0;
            cnt      <= '0;
            good_cnt <= '0;
            ho_cnt   <= '0;
            prev_ts  <= '0;
            pub_ts   <= '0;
        end else begin
            pps_q   <= pps_in;
            pps_out <= 1'b0;
            if (ev) begin
                prev_ts <= sample;
                cnt     <= '0;
            end else if (cnt != CNT_SAT) begin
                cnt <= cnt + CW'(1);
            end

            unique case (state_q)
                StSearch: begin
                    if (ev) begin
                        state_q              <= StAcquire;
                        {locked, holdover}   <= st_flags(StAcquire);
                        good_cnt             <= '0;
                    end
                end
                StAcquire: begin
                    if (ev) begin
                        if (!good) begin
                            good_cnt <= '0;
                        end else if (good_cnt + 4'd1 == LOCK_N) begin
                            state_q            <= StLocked;
                            {locked, holdover} <= st_flags(StLocked);
                            good_cnt           <= '0;
                            pps_out            <= 1'b1;
                            pub_ts             <= sample;
                        end else begin
                            good_cnt <= good_cnt + 4'd1;
                        end
                    end else if (cnt == CNT_TMO) begin
                        state_q            <= StSearch;
                        {locked, holdover} <= st_flags(StSearch);
                        good_cnt           <= '0;
                    end
                end
                StLocked: begin
                    if (ev) begin
                        pps_out <= 1'b1;
                        pub_ts  <= sample;
                        if (!good) begin
                            state_q            <= StAcquire;
                            {locked, holdover} <= st_flags(StAcquire);
                            good_cnt           <= '0;
                        end
                    end else if (cnt == CNT_TMO) begin
                        // The first free-run pulse counts as holdover second 1.
                        state_q            <= StHoldover;
                        {locked, holdover} <= st_flags(StHoldover);
                        pps_out            <= 1'b1;
                        pub_ts             <= ts_inc(pub_ts);
                        cnt                <= '0;
                        ho_cnt             <= 8'd1;
                    end
                end
                StHoldover: begin
                    if (ev) begin
                        state_q            <= StAcquire;
                        {locked, holdover} <= st_flags(StAcquire);
                        good_cnt           <= '0;
                        ho_cnt             <= '0;
                    end else if (cnt == CNT_NOM) begin
                        cnt <= '0;
                        if (ho_cnt >= HOLD_N) begin
                            state_q            <= StSearch;
                            {locked, holdover} <= st_flags(StSearch);
                            ho_cnt             <= '0;
                        end else begin
                            pps_out <= 1'b1;
                            pub_ts  <= ts_inc(pub_ts);
                            ho_cnt  <= ho_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q            <= StSearch;
                    {locked, holdover} <= st_flags(StSearch);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irig_sync_ctrl.sv
// Self-checking bench for irig_sync_ctrl with a scaled-down second (1000 cycles).
`timescale 1ns/1ps
module tb_irig_sync_ctrl;

    localparam int unsigned CLK_HZ       = 1000;
    localparam int unsigned PPS_TOL      = 10;
    localparam int unsigned LOCK_COUNT   = 3;
    localparam int unsigned HOLDOVER_MAX = 3;
    // Cycles from the last event to the first free-run pulse.
    localparam int TMO = CLK_HZ + PPS_TOL + 1;
    localparam int SEC = CLK_HZ;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pps_in = 1'b0;
    logic [16:0] ts_sec = '0;
    logic [8:0]  ts_day = '0;
    logic [6:0]  ts_year = '0;
    logic        pps_out;
    logic [16:0] sec_day_out;
    logic [8:0]  day_out;
    logic [6:0]  year_out;
    logic        locked;
    logic        holdover;
    logic [1:0]  state;

    irig_sync_ctrl #(
        .CLK_HZ      (CLK_HZ),
        .PPS_TOL     (PPS_TOL),
        .LOCK_COUNT  (LOCK_COUNT),
        .HOLDOVER_MAX(HOLDOVER_MAX)
    ) dut (
        .clk          (clk),
        .rst          (rst_n),
        .pps_in       (pps_in),
        .ts_sec_day_in(ts_sec),
        .ts_day_in    (ts_day),
        .ts_year_in   (ts_year),
        .pps_out      (pps_out),
        .sec_day_out  (sec_day_out),
        .day_out      (day_out),
        .year_out     (year_out),
        .locked       (locked),
        .holdover     (holdover),
        .state        (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sec;
        int day;
        int year;
        int cyc;
    } exp_t;

    typedef struct {
        int gap;
        int sec;
        int day;
        int year;
        int st;
        bit pub;
    } vec_t;

    exp_t exp_q[$];
    exp_t e;
    vec_t vecs[$];
    int   checks = 0;
    int   failures = 0;
    int   last_ev = 0;
    logic pps_prev = 1'b0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic void add(input int gap, input int sec, input int day, input int year,
                                input int st, input bit pub);
        vecs.push_back('{gap, sec, day, year, st, pub});
    endfunction

    // Raise pps_in so the event lands gap cycles after the previous one.
    task automatic send_event(input int gap, input int sec, input int day, input int year,
                              input bit pub);
        repeat (gap - 1) @(negedge clk);
        pps_in  = 1'b1;
        ts_sec  = 17'(sec);
        ts_day  = 9'(day);
        ts_year = 7'(year);
        last_ev = cyc + 1;
        if (pub) exp_q.push_back('{sec, day, year, cyc + 1});
        @(negedge clk);
        pps_in = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        send_event(v.gap, v.sec, v.day, v.year, v.pub);
        check("state", int'(state), v.st);
        check("locked", int'(locked), int'(v.st == 2));
        check("holdover", int'(holdover), 0);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Scoreboard: every qualified pulse must match the next queued publication.
    always @(negedge clk) begin
        if (rst_n && pps_out) begin
            check("pps_single_cycle", int'(pps_prev), 0);
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got pps_out=1 sec=%0d expected no pulse (cycle %0d)",
                         sec_day_out, cyc);
            end else begin
                e = exp_q.pop_front();
                check("pub_cycle", cyc, e.cyc);
                check("pub_sec", int'(sec_day_out), e.sec);
                check("pub_day", int'(day_out), e.day);
                check("pub_year", int'(year_out), e.year);
            end
        end
        pps_prev = pps_out;
    end

    initial begin
        #(90000 * 10);
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int ev2;
        // Lock on clean seconds.
        add(1000, 100, 50, 24, 1, 0);
        add(1000, 101, 50, 24, 1, 0);
        add(1000, 102, 50, 24, 1, 0);
        add(1000, 103, 50, 24, 2, 1);
        add(1000, 104, 50, 24, 2, 1);
        // Skipped second drops to ACQUIRE but still publishes.
        add(1000, 106, 50, 24, 1, 1);
        add(1000, 107, 50, 24, 1, 0);
        add(1000, 108, 50, 24, 1, 0);
        add(1000, 109, 50, 24, 2, 1);
        // Day 366 of a non-leap year: continuation to day 367 is out of range.
        add(1000, 86396, 366, 23, 1, 1);
        add(1000, 86397, 366, 23, 1, 0);
        add(1000, 86398, 366, 23, 1, 0);
        add(1000, 86399, 366, 23, 2, 1);
        add(1000, 0, 367, 23, 1, 1);
        // Same, continuing to 0/1/24, which is rejected.
        add(1000, 86397, 366, 23, 1, 0);
        add(1000, 86398, 366, 23, 1, 0);
        add(1000, 86399, 366, 23, 1, 0);
        add(1000, 86399, 366, 23, 1, 0);
        add(1000, 86396, 366, 23, 1, 0);
        add(1000, 86397, 366, 23, 1, 0);
        add(1000, 86398, 366, 23, 1, 0);
        add(1000, 86399, 366, 23, 2, 1);
        add(1000, 0, 1, 24, 1, 1);
        // Leap year: 86399/366/24 -> 0/1/25 accepted.
        add(1000, 86397, 366, 24, 1, 0);
        add(1000, 86398, 366, 24, 1, 0);
        add(1000, 86399, 366, 24, 1, 0);
        add(1000, 0, 1, 25, 2, 1);
        add(1000, 1, 1, 25, 2, 1);
        // Interval tolerance boundaries (valid spacing 990..1010).
        add(1010, 2, 1, 25, 2, 1);
        add(990, 3, 1, 25, 2, 1);
        add(989, 4, 1, 25, 1, 1);
        add(1000, 5, 1, 25, 1, 0);
        add(1000, 6, 1, 25, 1, 0);
        add(1000, 7, 1, 25, 2, 1);
        add(985, 8, 1, 25, 1, 1);
        add(1000, 9, 1, 25, 1, 0);
        add(1000, 10, 1, 25, 1, 0);
        add(1000, 11, 1, 25, 2, 1);
        add(1008, 12, 1, 25, 2, 1);
        // Century wrap 86399/365/99 -> 0/1/0.
        add(1000, 86396, 365, 99, 1, 1);
        add(1000, 86397, 365, 99, 1, 0);
        add(1000, 86398, 365, 99, 1, 0);
        add(1000, 86399, 365, 99, 2, 1);
        add(1000, 0, 1, 0, 2, 1);

        repeat (3) @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_holdover", int'(holdover), 0);
        check("rst_pps_out", int'(pps_out), 0);
        check("rst_sec", int'(sec_day_out), 0);
        check("rst_day", int'(day_out), 0);
        check("rst_year", int'(year_out), 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Holdover: three free-run pulses, then SEARCH with no further pulse.
        ev2 = last_ev;
        exp_q.push_back('{1, 1, 0, ev2 + TMO});
        exp_q.push_back('{2, 1, 0, ev2 + TMO + SEC});
        exp_q.push_back('{3, 1, 0, ev2 + TMO + 2 * SEC});
        wait_until(ev2 + TMO - 1);
        check("pre_holdover_state", int'(state), 2);
        wait_until(ev2 + TMO);
        check("holdover_state", int'(state), 3);
        check("holdover_flag", int'(holdover), 1);
        check("holdover_locked", int'(locked), 0);
        wait_until(ev2 + TMO + 3 * SEC - 1);
        check("holdover_last_state", int'(state), 3);
        wait_until(ev2 + TMO + 3 * SEC);
        check("holdover_exit_state", int'(state), 0);
        check("holdover_exit_flag", int'(holdover), 0);
        wait_until(ev2 + TMO + 4 * SEC + 200);
        check("holdover_queue_empty", exp_q.size(), 0);
        check("holdover_sec_held", int'(sec_day_out), 3);

        // Event coincident with an internal holdover pulse: event wins.
        run_vec('{1000, 10, 1, 0, 1, 0});
        run_vec('{1000, 11, 1, 0, 1, 0});
        run_vec('{1000, 12, 1, 0, 1, 0});
        run_vec('{1000, 13, 1, 0, 2, 1});
        exp_q.push_back('{14, 1, 0, last_ev + TMO});
        send_event(TMO + SEC, 50, 1, 0, 0);
        check("coinc_state", int'(state), 1);
        check("coinc_pps_out", int'(pps_out), 0);
        check("coinc_sec", int'(sec_day_out), 14);
        check("coinc_holdover", int'(holdover), 0);
        // ACQUIRE times out to SEARCH when no event follows.
        ev2 = last_ev;
        wait_until(ev2 + TMO - 1);
        check("acq_pre_timeout", int'(state), 1);
        wait_until(ev2 + TMO);
        check("acq_timeout", int'(state), 0);

        // Reset mid-second loses everything; reacquire needs LOCK_COUNT+1 events.
        run_vec('{1000, 30, 2, 0, 1, 0});
        run_vec('{1000, 31, 2, 0, 1, 0});
        run_vec('{1000, 32, 2, 0, 1, 0});
        run_vec('{1000, 33, 2, 0, 2, 1});
        repeat (400) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_state", int'(state), 0);
        check("midrst_locked", int'(locked), 0);
        check("midrst_sec", int'(sec_day_out), 0);
        check("midrst_day", int'(day_out), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        run_vec('{1000, 34, 2, 0, 1, 0});
        run_vec('{1000, 35, 2, 0, 1, 0});
        run_vec('{1000, 36, 2, 0, 1, 0});
        run_vec('{1000, 37, 2, 0, 2, 1});
        run_vec('{1000, 38, 2, 0, 2, 1});
        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
